// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Groups the pipeline-facing signals of the hazard controller.
//   master : pipeline side. It drives the stage instructions, operand use
//            times, destination info and mult/div controls. It receives the
//            stall/flush controls, MD_Busy and Stall_Count.
//   slave  : hazard controller side. Its directions are the mirror of master.
// Stage instructions: rs = [25:21], rt = [20:16].
// Tuse value 3 means that the operand is not read.
// Data_To_Reg encoding: 00 ALU_OUT, 01 MEM, 10 PC_8.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [31:0] Instr_D;
  logic [31:0] Instr_E;
  logic [31:0] Instr_M;
  logic [1:0]  Tuse_Rs_D;
  logic [1:0]  Tuse_Rt_D;
  logic [4:0]  Write_Addr_E;
  logic [4:0]  Write_Addr_M;
  logic        Write_Enabled_E;
  logic        Write_Enabled_M;
  logic [1:0]  Data_To_Reg_E;
  logic [1:0]  Data_To_Reg_M;
  logic        MD_Start_E;
  logic        MD_Is_Div_E;
  logic        MD_Use_D;
  logic        Stall_F;
  logic        Stall_D;
  logic        Flush_E;
  logic        MD_Busy;
  logic [15:0] Stall_Count;

  modport master (
    output Instr_D, Instr_E, Instr_M, Tuse_Rs_D, Tuse_Rt_D,
           Write_Addr_E, Write_Addr_M, Write_Enabled_E, Write_Enabled_M,
           Data_To_Reg_E, Data_To_Reg_M, MD_Start_E, MD_Is_Div_E, MD_Use_D,
    input  Stall_F, Stall_D, Flush_E, MD_Busy, Stall_Count
  );

  modport slave (
    input  Instr_D, Instr_E, Instr_M, Tuse_Rs_D, Tuse_Rt_D,
           Write_Addr_E, Write_Addr_M, Write_Enabled_E, Write_Enabled_M,
           Data_To_Reg_E, Data_To_Reg_M, MD_Start_E, MD_Is_Div_E, MD_Use_D,
    output Stall_F, Stall_D, Flush_E, MD_Busy, Stall_Count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for a 5-stage MIPS-style pipeline.
//
// Data hazards: a D-stage operand stalls when an older instruction in E or M
// writes the same non-zero GPR and produces it later than D needs it. Here
// "later" means the D-stage Tuse is less than the stage Tnew.
// Mult/div hazards: an instruction in D that uses the mult/div unit or HI/LO
// stalls while a mult/div operation starts in E or is still busy.
//
// Optional feature macro: MD_UNIT_EN.
//   defined   : the mult/div busy counter and the MD stall are built.
//   undefined : there is no counter, MD_Busy is tied 0 and the MD_* inputs
//               are ignored.
//
// Ports
//   clk    : the single clock, rising edge.
//   reset  : synchronous, active-high reset. It clears the busy counter and
//            Stall_Count.
//   bus    : hazard_ctrl_if.slave. It carries these signals:
//            - stage inputs;
//            - Stall_F/Stall_D/Flush_E, which are combinational and equal
//              the stall term of the same cycle;
//            - MD_Busy and Stall_Count, which are registered.
// Parameters
//   MULT_CYCLES : busy cycles loaded for a multiply (default 5).
//   DIV_CYCLES  : busy cycles loaded for a divide (default 10).
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  // Cycle count after which the E-stage result is ready for forwarding.
  function automatic logic [1:0] tnew_e_f(input logic [1:0] dtr);
    logic [1:0] tnew;
    case (dtr)
      2'b01:   tnew = 2'd2;
      2'b00:   tnew = 2'd1;
      default: tnew = 2'd0;
    endcase
    return tnew;
  endfunction

  // Only a load still in M is not yet available for forwarding.
  function automatic logic [1:0] tnew_m_f(input logic [1:0] dtr);
    logic [1:0] tnew;
    case (dtr)
      2'b01:   tnew = 2'd1;
      default: tnew = 2'd0;
    endcase
    return tnew;
  endfunction

  // Hazard for one D-stage source operand against the E and M producers.
  function automatic logic operand_stall_f(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [1:0] tnew_e,
    input logic [1:0] tnew_m,
    input logic [4:0] wa_e,
    input logic       we_e,
    input logic [4:0] wa_m,
    input logic       we_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == wa_e) && we_e && (tuse < tnew_e);
    hit_m = (src == wa_m) && we_m && (tuse < tnew_m);
    return (src != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [1:0]  tnew_e_s;
  logic [1:0]  tnew_m_s;
  logic        data_stall_s;
  logic        md_stall_s;
  logic        stall_s;
  logic        md_busy_r;
  logic [15:0] stall_cnt_r;

  assign rs_s     = bus.Instr_D[25:21];
  assign rt_s     = bus.Instr_D[20:16];
  assign tnew_e_s = tnew_e_f(bus.Data_To_Reg_E);
  assign tnew_m_s = tnew_m_f(bus.Data_To_Reg_M);

  // Data stall: OR of the rs and rt operand hazards.
  always_comb begin
    data_stall_s = 1'b0;
    if (operand_stall_f(rs_s, bus.Tuse_Rs_D, tnew_e_s, tnew_m_s,
                        bus.Write_Addr_E, bus.Write_Enabled_E,
                        bus.Write_Addr_M, bus.Write_Enabled_M)) begin
      data_stall_s = 1'b1;
    end else if (operand_stall_f(rt_s, bus.Tuse_Rt_D, tnew_e_s, tnew_m_s,
                                 bus.Write_Addr_E, bus.Write_Enabled_E,
                                 bus.Write_Addr_M, bus.Write_Enabled_M)) begin
      data_stall_s = 1'b1;
    end else begin
      data_stall_s = 1'b0;
    end
  end

`ifdef MD_UNIT_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LD  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] md_cnt_r;
  logic [CNT_W-1:0] md_load_s;
  logic             unused_s;

  assign md_load_s = bus.MD_Is_Div_E ? DIV_LD : MULT_LD;

  // Mult/div busy counter. A start always reloads, and the last start wins,
  // even while the D stage stalls, because the E instruction still advances.
  // The busy flag tracks (counter != 0) as a register, so it rises one cycle
  // after the start.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_r  <= CNT_ZERO;
      md_busy_r <= 1'b0;
    end else if (bus.MD_Start_E) begin
      md_cnt_r  <= md_load_s;
      md_busy_r <= (md_load_s != CNT_ZERO);
    end else if (md_cnt_r != CNT_ZERO) begin
      md_cnt_r  <= md_cnt_r - CNT_ONE;
      md_busy_r <= (md_cnt_r != CNT_ONE);
    end else begin
      md_cnt_r  <= md_cnt_r;
      md_busy_r <= 1'b0;
    end
  end

  assign md_stall_s = bus.MD_Use_D && (bus.MD_Start_E || md_busy_r);
  assign unused_s   = ^{bus.Instr_D[31:26], bus.Instr_D[15:0],
                        bus.Instr_E, bus.Instr_M};
`else
  logic unused_s;

  // The mult/div unit is not built, so the busy flag is tied low.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_busy_r <= 1'b0;
    end else begin
      md_busy_r <= 1'b0;
    end
  end

  assign md_stall_s = 1'b0;
  assign unused_s   = ^{bus.Instr_D[31:26], bus.Instr_D[15:0],
                        bus.Instr_E, bus.Instr_M,
                        bus.MD_Start_E, bus.MD_Is_Div_E, bus.MD_Use_D,
                        1'(MULT_CYCLES), 1'(DIV_CYCLES)};
`endif

  assign stall_s = data_stall_s || md_stall_s;

  // Saturating stall-cycle counter. It holds at all ones and never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.Stall_F     = stall_s;
  assign bus.Stall_D     = stall_s;
  assign bus.Flush_E     = stall_s;
  assign bus.MD_Busy     = md_busy_r;
  assign bus.Stall_Count = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl.
// Inputs are driven after the falling edge. Outputs are checked 1 ns later.
// The reference model then advances at the rising edge.
// The reference model works on the following terms:
//   - operand hazard rules from readiness times;
//   - an absolute "busy until cycle N" mark for the mult/div unit;
//   - a plain integer stall count clipped at 65535.
// MD checks follow MD_UNIT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef MD_UNIT_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;   // index of the current cycle between rising edges
  int busy_end   = -1;  // the unit is busy in every cycle <= busy_end
  int stall_cnt  = 0;
  bit exp_stall;

  // Cycles until a producer's result can be forwarded.
  function automatic int ready_e(input logic [1:0] dtr);
    if (dtr == 2'b01) return 2;
    if (dtr == 2'b00) return 1;
    return 0;
  endfunction

  function automatic int ready_m(input logic [1:0] dtr);
    return (dtr == 2'b01) ? 1 : 0;
  endfunction

  function automatic bit needs_wait(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 5'd0 || tuse == 2'd3) return 1'b0;
    if (bus.Write_Enabled_E && bus.Write_Addr_E == r &&
        int'(tuse) < ready_e(bus.Data_To_Reg_E)) return 1'b1;
    if (bus.Write_Enabled_M && bus.Write_Addr_M == r &&
        int'(tuse) < ready_m(bus.Data_To_Reg_M)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return MD_EN && (cyc <= busy_end);
  endfunction

  function automatic bit model_stall();
    bit d;
    bit m;
    d = needs_wait(bus.Instr_D[25:21], bus.Tuse_Rs_D) ||
        needs_wait(bus.Instr_D[20:16], bus.Tuse_Rt_D);
    m = MD_EN && bus.MD_Use_D && (bus.MD_Start_E || model_busy());
    return d || m;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic advance();
    exp_stall = model_stall();
    @(posedge clk);
    if (reset) begin
      busy_end  = cyc;
      stall_cnt = 0;
    end else begin
      if (bus.MD_Start_E) busy_end = cyc + (bus.MD_Is_Div_E ? DIV_N : MULT_N);
      if (exp_stall && stall_cnt < 65535) stall_cnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Check every output against the model, then advance by one cycle.
  task automatic step(input string tag);
    logic [2:0]  exp3;
    logic [2:0]  got3;
    logic        exp_b;
    logic [15:0] exp_c;
    #1;
    exp3  = {3{model_stall()}};
    got3  = {bus.Stall_F, bus.Stall_D, bus.Flush_E};
    exp_b = model_busy();
    exp_c = 16'(stall_cnt);
    vectors++;
    assert (got3 === exp3) else begin
      miscompares++;
      $error("FAIL %s stall/flush: got %b expected %b", tag, got3, exp3);
    end
    vectors++;
    assert (bus.MD_Busy === exp_b) else begin
      miscompares++;
      $error("FAIL %s MD_Busy: got %b expected %b", tag, bus.MD_Busy, exp_b);
    end
    vectors++;
    assert (bus.Stall_Count === exp_c) else begin
      miscompares++;
      $error("FAIL %s Stall_Count: got %0d expected %0d", tag, bus.Stall_Count, exp_c);
    end
    advance();
  endtask

  task automatic idle_inputs();
    bus.Instr_D = 32'd0;  bus.Instr_E = 32'd0;  bus.Instr_M = 32'd0;
    bus.Tuse_Rs_D = 2'd3; bus.Tuse_Rt_D = 2'd3;
    bus.Write_Addr_E = 5'd0; bus.Write_Addr_M = 5'd0;
    bus.Write_Enabled_E = 1'b0; bus.Write_Enabled_M = 1'b0;
    bus.Data_To_Reg_E = 2'b00; bus.Data_To_Reg_M = 2'b00;
    bus.MD_Start_E = 1'b0; bus.MD_Is_Div_E = 1'b0; bus.MD_Use_D = 1'b0;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt);
    bus.Instr_D   = {6'd4, rs, rt, 16'h0010};
    bus.Tuse_Rs_D = tu_rs;
    bus.Tuse_Rt_D = tu_rt;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    advance();                     // first reset edge; the outputs are now defined
    step("reset_hold");

    // Load-use before a branch: two stall cycles, then release.
    reset = 1'b0;
    set_d(5'd8, 5'd0, 2'd0, 2'd3);
    bus.Write_Addr_E = 5'd8; bus.Write_Enabled_E = 1'b1; bus.Data_To_Reg_E = 2'b01;
    step("beq_lw_E");
    bus.Write_Enabled_E = 1'b0;
    bus.Write_Addr_M = 5'd8; bus.Write_Enabled_M = 1'b1; bus.Data_To_Reg_M = 2'b01;
    step("beq_lw_M");
    bus.Write_Enabled_M = 1'b0;
    #1;
    vectors++;
    assert (bus.Stall_Count === 16'd2) else begin
      miscompares++;
      $error("FAIL beq_count: got %0d expected 2", bus.Stall_Count);
    end
    step("beq_done");

    // $0 never causes a hazard.
    set_d(5'd0, 5'd0, 2'd1, 2'd3);
    bus.Write_Addr_E = 5'd0; bus.Write_Enabled_E = 1'b1; bus.Data_To_Reg_E = 2'b01;
    step("addu_r0");

    // A store data operand read late enough to take a load from E.
    set_d(5'd0, 5'd9, 2'd3, 2'd2);
    bus.Write_Addr_E = 5'd9; bus.Data_To_Reg_E = 2'b01;
    step("sw_lw_E");

    // ALU result in E against Tuse 0 stalls; PC_8 does not.
    set_d(5'd3, 5'd9, 2'd0, 2'd0);
    bus.Data_To_Reg_E = 2'b00;
    step("alu_rt_tuse0");
    bus.Data_To_Reg_E = 2'b10;
    step("pc8_no_stall");
    idle_inputs();

    // A divide followed by a mult/div user held in D.
    bus.MD_Start_E = 1'b1; bus.MD_Is_Div_E = 1'b1; bus.MD_Use_D = 1'b1;
    step("div_start");
    bus.MD_Start_E = 1'b0; bus.MD_Is_Div_E = 1'b0;
    for (int i = 0; i < DIV_N + 2; i++) step($sformatf("div_busy%0d", i));
    bus.MD_Use_D = 1'b0;

    // Reset in the middle of a divide aborts the busy period.
    bus.MD_Start_E = 1'b1; bus.MD_Is_Div_E = 1'b1;
    step("div2_start");
    bus.MD_Start_E = 1'b0;
    for (int i = 0; i < 6; i++) step($sformatf("div2_run%0d", i));
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    bus.MD_Use_D = 1'b1;
    step("after_reset");
    bus.MD_Use_D = 1'b0;

    // Randomized traffic on a small register range so that hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      bus.Instr_D[31:26] = 6'($urandom);
      bus.Instr_E = $urandom; bus.Instr_M = $urandom;
      bus.Write_Addr_E = 5'($urandom_range(0, 3));
      bus.Write_Addr_M = 5'($urandom_range(0, 3));
      bus.Write_Enabled_E = 1'($urandom); bus.Write_Enabled_M = 1'($urandom);
      bus.Data_To_Reg_E = 2'($urandom); bus.Data_To_Reg_M = 2'($urandom);
      bus.MD_Start_E = ($urandom_range(0, 7) == 0);
      bus.MD_Is_Div_E = 1'($urandom);
      bus.MD_Use_D = 1'($urandom);
      step($sformatf("rand%0d", i));
    end

    // Saturation: a long run of forced stall cycles.
    idle_inputs();
    reset = 1'b1;
    step("sat_reset");
    reset = 1'b0;
    set_d(5'd5, 5'd0, 2'd0, 2'd3);
    bus.Write_Addr_E = 5'd5; bus.Write_Enabled_E = 1'b1; bus.Data_To_Reg_E = 2'b01;
    for (int i = 0; i < 65534; i++) advance();
    step("sat_near");
    for (int i = 0; i < 4464; i++) advance();
    step("sat_full");
    idle_inputs();
    step("sat_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
